// File: rtl/dh_responder.sv
// Diffie-Hellman responder: receives A, computes and sends B = g^b mod p, then K = A^b mod p.
// Optional public-value range check is enabled by defining DH_PUBKEY_CHECK_EN.
`timescale 1ns/1ps
module dh_responder #(
  parameter int WIDTH     = 100,
  parameter int EXP_WIDTH = 101,
  parameter int NBYTES    = (WIDTH+7)/8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     prime,
  input  logic [WIDTH-1:0]     gen,
  input  logic [EXP_WIDTH-1:0] priv_exp,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [WIDTH-1:0]     shared_key,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err
);
  localparam int BW = 8*NBYTES;
  localparam int CW = $clog2(EXP_WIDTH+1);
  localparam int KW = $clog2(NBYTES+1);
  localparam logic [CW-1:0] EXP_END = CW'(EXP_WIDTH);
  localparam logic [KW-1:0] LAST_B  = KW'(NBYTES-1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_EXP_B, S_TX, S_EXP_K, S_DONE} state_t;

  // Modulus 0 is illegal; returning 0 keeps the datapath defined so the FSM still completes.
  function automatic logic [WIDTH-1:0] f_mod(input logic [2*WIDTH-1:0] x, input logic [WIDTH-1:0] m);
    if (m == '0) return '0;
    return WIDTH'(x % (2*WIDTH)'(m));
  endfunction

  state_t               r_state;
  logic [BW-1:0]        r_rx;
  logic [KW-1:0]        r_cnt;
  logic [KW-1:0]        r_k;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_base;
  logic [CW-1:0]        r_bitcnt;
  logic [BW-1:0]        r_txsh;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_rx_ready;
  logic [WIDTH-1:0]     r_key;
  logic                 r_key_valid;
  logic                 r_busy;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_acc_mul;
  logic [WIDTH-1:0]     w_base_sq;
  logic [BW-1:0]        w_accpad;
  logic                 w_bit;

  assign w_a       = r_rx[WIDTH-1:0];
  assign w_acc_mul = f_mod((2*WIDTH)'(r_acc) * (2*WIDTH)'(r_base), prime);
  assign w_base_sq = f_mod((2*WIDTH)'(r_base) * (2*WIDTH)'(r_base), prime);
  assign w_accpad  = BW'(r_acc);
  assign w_bit     = (r_bitcnt < EXP_END) ? priv_exp[r_bitcnt] : 1'b0;

  assign rx_ready   = r_rx_ready;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign shared_key = r_key;
  assign key_valid  = r_key_valid;
  assign busy       = r_busy;

`ifdef DH_PUBKEY_CHECK_EN
  logic r_err;
  logic w_bad_a;
  assign w_bad_a = (w_a == '0) || (w_a == WIDTH'(1)) || (w_a >= prime);
  assign err     = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rx        <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      r_base      <= '0;
      r_bitcnt    <= '0;
      r_txsh      <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DH_PUBKEY_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (rx_valid && r_rx_ready) begin
            r_key_valid <= 1'b0;
`ifdef DH_PUBKEY_CHECK_EN
            r_err       <= 1'b0;
`endif
            r_busy      <= 1'b1;
            r_rx        <= BW'(rx_data);
            r_cnt       <= KW'(1);
            if (NBYTES == 1) begin
              r_rx_ready <= 1'b0;
              r_state    <= S_CHECK;
            end else begin
              r_state    <= S_RX;
            end
          end
        end
        S_RX: begin
          if (rx_valid) begin
            r_rx  <= {r_rx[BW-9:0], rx_data};
            r_cnt <= r_cnt + KW'(1);
            if (r_cnt == LAST_B) begin
              r_rx_ready <= 1'b0;
              r_state    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          r_a      <= w_a;
          r_base   <= f_mod((2*WIDTH)'(gen), prime);
          r_acc    <= f_mod((2*WIDTH)'(1), prime);
          r_bitcnt <= '0;
          r_state  <= S_EXP_B;
`ifdef DH_PUBKEY_CHECK_EN
          if (w_bad_a) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
`endif
        end
        S_EXP_B, S_EXP_K: begin
          if (r_bitcnt == EXP_END) begin
            // One extra cycle after the last bit latches the result.
            if (r_state == S_EXP_B) begin
              r_txsh     <= w_accpad << 8;
              r_tx_data  <= w_accpad[BW-1 -: 8];
              r_tx_valid <= 1'b1;
              r_k        <= '0;
              r_state    <= S_TX;
            end else begin
              r_state    <= S_DONE;
            end
          end else begin
            if (w_bit) r_acc <= w_acc_mul;
            r_base   <= w_base_sq;
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
        S_TX: begin
          if (tx_ready) begin
            if (r_k == LAST_B) begin
              r_tx_valid <= 1'b0;
              r_base     <= f_mod((2*WIDTH)'(r_a), prime);
              r_acc      <= f_mod((2*WIDTH)'(1), prime);
              r_bitcnt   <= '0;
              r_state    <= S_EXP_K;
            end else begin
              r_k       <= r_k + KW'(1);
              r_tx_data <= r_txsh[BW-1 -: 8];
              r_txsh    <= r_txsh << 8;
            end
          end
        end
        S_DONE: begin
          r_key       <= r_acc;
          r_key_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_rx_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dh_responder.md
Name: dh_responder

Overview:
- Responder end of the Diffie-Hellman exchange whose initiator side uses our modular exponentiator.
- Accepts the peer public value A as a byte stream and computes its own public value B = g^b mod p. It returns B as a byte stream, then computes the shared key K = A^b mod p.
- Self-contained: contains its own iterative square-and-multiply engine, one exponent bit per cycle.
- Sits between the link byte interface and the key consumer.

Parameters:
- WIDTH, 100, bit width of prime, generator, public values and key.
- EXP_WIDTH, 101, bit width of the private exponent.
- NBYTES, (WIDTH+7)/8, bytes per public value on the byte interface (derived).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- prime  in  WIDTH  modulus p; must be stable while busy=1.
- gen  in  WIDTH  generator g; stable while busy=1.
- priv_exp  in  EXP_WIDTH  private exponent b; stable while busy=1.
- rx_data  in  8  incoming byte of A, MSB byte first.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  responder accepts a byte this cycle.
- tx_data  out  8  outgoing byte of B, MSB byte first.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts tx_data this cycle.
- shared_key  out  WIDTH  K; valid when key_valid=1.
- key_valid  out  1  K valid; level signal.
- busy  out  1  exchange in progress.
- err  out  1  exchange aborted, A rejected; level signal.

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, shared_key=0, key_valid=0, busy=0, err=0. FSM goes to IDLE; all counters and registers clear.
- Reset mid-operation: abort immediately and return to IDLE next cycle. No partial bytes are emitted after reset.
- States and transitions:
  - IDLE: rx_ready=1, busy=0. The first accepted byte (rx_valid&rx_ready) clears key_valid and err, stores the byte and goes to RX.
  - RX: rx_ready=1, busy=1. Bytes shift into a (8*NBYTES)-bit register. After byte NBYTES is accepted, go to CHECK. rx_ready=0 in every state other than IDLE/RX.
  - CHECK (1 cycle): A = low WIDTH bits of the register; excess high bits of the first byte are ignored. Range handling is set by the optional feature. Load the engine with base=g, acc=1, exp=b, bitcnt=0. Go to EXP_B.
  - EXP_B (exactly EXP_WIDTH cycles), per cycle at bit i (LSB first):
    - if b[i]: acc <= (acc*base) mod p;
    - base <= (base*base) mod p;
    - products are 2*WIDTH bits wide, no truncation before the mod.
    - After the last bit, latch B=acc and go to TX.
  - TX: tx_valid=1 with tx_data = byte k of B (k=0 is the MSB byte, zero-padded to 8*NBYTES). Advance k only on tx_valid&tx_ready. tx_data must hold stable while tx_valid=1 and tx_ready=0. After byte NBYTES-1 handshakes, tx_valid drops next cycle and the FSM goes to EXP_K.
  - EXP_K: same engine as EXP_B with base=A (reduced mod p), acc=1, exp=b, EXP_WIDTH cycles.
  - DONE (1 cycle): shared_key<=acc, key_valid<=1, busy<=0, go to IDLE.
- key_valid and shared_key hold until the next exchange's first byte or reset.
- Fixed latency: last rx byte accepted → first tx_valid = 1+EXP_WIDTH+1 cycles. Last tx handshake → key_valid = EXP_WIDTH+2 cycles.
- Arithmetic corner cases:
  - b=0 gives B=1 and K=1.
  - p=1 gives all results 0 (mod 1).
  - p=0 is illegal; behaviour is unspecified but the FSM must still complete and return to IDLE.
- Simultaneous rx_valid in non-RX states is ignored; the byte is not consumed.

Optional Feature:
- Macro: DH_PUBKEY_CHECK_EN.
- Defined: in CHECK, if A==0, A==1, or A>=p:
  - err<=1, busy<=0, key_valid stays 0;
  - return to IDLE with no TX and no exponentiation.
- Undefined: no check and err is tied 0. A is reduced mod p before EXP_K; A=0 yields K=0 for b>0.

Test Plan (WIDTH=16, EXP_WIDTH=17, NBYTES=2; p=23, g=5, b=15):
- Basic exchange: send A bytes 0x00,0x08 with tx_ready=1 → tx bytes 0x00,0x13 (B=19); then key_valid=1 with shared_key=2; first tx_valid exactly 19 cycles after the last rx byte.
- Backpressure: same exchange with tx_ready low for 5 cycles on each byte → tx_data held stable, same B=19, K=2; no byte duplicated or dropped.
- Zero exponent: b=0, A=0x0008 → B=1 (bytes 0x00,0x01), K=1.
- Range check (DH_PUBKEY_CHECK_EN defined): A=0x0017 (=p) → err=1, no tx_valid, key_valid=0. Without the macro: A=0x0017 → B=19, K=0.
- Reset mid-exchange: assert rst for 1 cycle during EXP_B → all outputs return to reset values, no tx bytes; a following normal exchange still gives B=19, K=2.
- Back-to-back exchanges: second exchange with A=0x0002 after DONE → key_valid drops on the first rx byte, then K=2^15 mod 23 = 16.
